// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: acks every received byte, assembles [SOF, ADDR, LEN, PAYLOAD, CHK]
// frames, and hands checksum-good frames to the command layer over a valid/ready handshake.
module uart_rx_frame_ctrl #(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SOF         = 8'hA5,
    parameter int         TIMEOUT_CYC = 4160,
    localparam int        LW          = $clog2(MAX_LEN + 1),
    localparam int        IW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int        TW          = $clog2(TIMEOUT_CYC)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_data_ready,
    input  logic          rx_busy,
    output logic          rst_data_rdy,
    output logic          frm_valid,
    input  logic          frm_ready,
    output logic [7:0]    frm_addr,
    output logic [LW-1:0] frm_len,
    input  logic [LW-1:0] rd_idx,
    output logic [7:0]    rd_byte,
    output logic          err_chk,
    output logic          err_len,
    output logic          err_to,
    output logic          err_ovf
);

    // IDLE: hunt SOF | ADDR/LEN/PAYLOAD/CHK: in frame, timer armed | HOLD: frame offered
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_CHK, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      sum_q, sum_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ack_q;
    logic            err_chk_q, err_chk_d;
    logic            err_len_q, err_len_d;
    logic            err_to_q, err_to_d;
    logic            err_ovf_q, err_ovf_d;
    logic            accept;
    logic            in_frame;
    logic            buf_we;
    logic [7:0]      chk_sum;
    logic [7:0]      buf_q [MAX_LEN];

    // DATA_READY is still high during the ack cycle; ignoring it there prevents a double accept
    assign accept   = rx_data_ready && !ack_q;
    assign in_frame = state_q inside {S_ADDR, S_LEN, S_PAYLOAD, S_CHK};
    assign chk_sum  = sum_q + rx_data;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sum_d     = sum_q;
        len_d     = len_q;
        idx_d     = idx_q;
        timer_d   = '0;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_to_d  = 1'b0;
        err_ovf_d = 1'b0;
        buf_we    = 1'b0;

        if (in_frame && !accept) begin
            if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                err_to_d = 1'b1;
                state_d  = S_IDLE;
            end else if (!rx_busy) begin
                timer_d = timer_q + TW'(1);
            end else begin
                timer_d = timer_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept && rx_data == SOF) begin
                    sum_d   = 8'h00;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (accept) begin
                    addr_d  = rx_data;
                    sum_d   = rx_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (rx_data == 8'h00 || rx_data > 8'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        len_d   = rx_data[LW-1:0];
                        idx_d   = '0;
                        sum_d   = chk_sum;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    buf_we = 1'b1;
                    sum_d  = chk_sum;
                    idx_d  = idx_q + LW'(1);
                    if (idx_q == len_q - LW'(1)) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    if (chk_sum == 8'h00) begin
                        state_d = S_HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                // a byte arriving while a frame is held is dropped, even on the release cycle
                if (accept) begin
                    err_ovf_d = 1'b1;
                end
                if (frm_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= 8'h00;
            sum_q     <= 8'h00;
            len_q     <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            ack_q     <= 1'b0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sum_q     <= sum_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            ack_q     <= accept;
            err_chk_q <= err_chk_d;
            err_len_q <= err_len_d;
            err_to_q  <= err_to_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[idx_q[IW-1:0]] <= rx_data;
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        if (rd_idx < len_q) begin
            rd_byte = buf_q[rd_idx[IW-1:0]];
        end
    end

    assign rst_data_rdy = ack_q;
    assign frm_valid    = (state_q == S_HOLD);
    assign frm_addr     = addr_q;
    assign frm_len      = len_q;
    assign err_chk      = err_chk_q;
    assign err_len      = err_len_q;
    assign err_to       = err_to_q;
    assign err_ovf      = err_ovf_q;

endmodule
